// File: rtl/alu_result_demux_pkg.sv
// alu_result_demux_pkg: constants shared by the ALU result demux and the ALU operand mux
package alu_result_demux_pkg;
  localparam int ALU_RESULT_W = 32;
  localparam logic DEMUX_SEL_A = 1'b1;
  localparam logic DEMUX_SEL_B = 1'b0;
endpackage

// File: rtl/demux_chan_fifo.sv
// demux_chan_fifo: one output channel FIFO of the ALU result demux
// ports: clk/rst_n; i_push+i_data write side (caller guarantees !o_full);
// o_valid/i_ready/o_data read side; o_count occupancy; o_full = count==DEPTH
module demux_chan_fifo
  import alu_result_demux_pkg::*;
#(
  parameter int WIDTH = ALU_RESULT_W,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [PTR_W:0]   o_count,
  output logic             o_full
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [PTR_W:0]   r_cnt;
  logic             w_pop;
  assign o_valid = r_cnt != '0;
  assign o_full  = r_cnt == (PTR_W+1)'(DEPTH);
  assign o_count = r_cnt;
  assign w_pop   = o_valid && i_ready;
  // outputs are masked while empty so stale storage never leaks out
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_data;
  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= i_push ? r_wr + 1'b1 : r_wr;
      r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt <= r_cnt + (PTR_W+1)'(i_push) - (PTR_W+1)'(w_pop);
    end
endmodule

// File: rtl/alu_result_demux.sv
// alu_result_demux: registered 1-to-2 distributor steering ALU results to channel A/B FIFOs
// ports: clk/rst_n; in_valid/in_ready/in_data/in_sel producer side (sel 1 = A, 0 = B);
// a_*/b_* consumer handshakes with head data; a_count/b_count occupancy 0..DEPTH
module alu_result_demux
  import alu_result_demux_pkg::*;
#(
  parameter int WIDTH = ALU_RESULT_W,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [PTR_W:0]   a_count,
  output logic [PTR_W:0]   b_count
);
  logic w_sel_a, w_a_full, w_b_full, w_fire;
  assign w_sel_a  = in_sel == DEMUX_SEL_A;
  // depends only on registered fullness: a full channel never accepts, even while popping
  assign in_ready = w_sel_a ? !w_a_full : !w_b_full;
  assign w_fire   = in_valid && in_ready;
  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_a (
    .clk(clk), .rst_n(rst_n), .i_push(w_fire && w_sel_a), .i_data(in_data),
    .o_valid(a_valid), .i_ready(a_ready), .o_data(a_data), .o_count(a_count), .o_full(w_a_full)
  );
  demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_b (
    .clk(clk), .rst_n(rst_n), .i_push(w_fire && !w_sel_a), .i_data(in_data),
    .o_valid(b_valid), .i_ready(b_ready), .o_data(b_data), .o_count(b_count), .o_full(w_b_full)
  );
endmodule

// File: doc/alu_result_demux.md
Name: alu_result_demux

Overview:
- Registered 1-to-2 result distributor at the ALU output. It is the counterpart of the operand-select mux on the ALU input.
- Accepts one 32-bit result per cycle over a valid/ready handshake and steers it by `sel` to channel A (`sel`=1) or channel B (`sel`=0). The select convention matches the input-side mux.
- Each channel has its own small FIFO, so a stalled consumer does not block the other channel's data already queued.

Parameters:
- WIDTH, 32, data width of each result word.
- DEPTH, 2, entries per channel FIFO; must be a power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a result.
- in_ready  output  1  result accepted this cycle if in_valid is also high.
- in_data  input  WIDTH  result word.
- in_sel  input  1  1 = channel A, 0 = channel B.
- a_valid  output  1  channel A head entry valid.
- a_ready  input  1  channel A consumer accepts head.
- a_data  output  WIDTH  channel A head word.
- b_valid  output  1  channel B head entry valid.
- b_ready  input  1  channel B consumer accepts head.
- b_data  output  WIDTH  channel B head word.
- a_count  output  PTR_W+1  channel A occupancy, 0..DEPTH.
- b_count  output  PTR_W+1  channel B occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): all FIFO pointers and counts go to 0. a_valid=0, b_valid=0, a_count=0, b_count=0. a_data/b_data=0. Storage contents are don't-care, but the outputs are masked to 0 while the channel is empty.
- Reset mid-operation discards every queued entry; no word is delivered after rst_n rises.
- in_ready = in_sel ? (a_count != DEPTH) : (b_count != DEPTH).
  - This is combinational from in_sel and the registered counts only; there is no path from a_ready/b_ready.
  - When the target channel is full, in_ready=0 even if that channel is popping the same cycle (no full-pass-through).
- Push: on a clock edge with in_valid && in_ready, in_data is written at the selected channel's write pointer. That write pointer increments modulo DEPTH and wraps DEPTH-1 -> 0.
- Pop: on a clock edge with x_valid && x_ready, the read pointer increments modulo DEPTH.
- x_valid = (x_count != 0). x_data = mem[rd_ptr] when x_valid.
- Latency: a word pushed at edge N is visible on x_valid/x_data after edge N. There is no same-cycle bypass.
- Simultaneous push and pop on the same channel (not full, not empty): count is unchanged and both pointers advance.
- Simultaneous push and pop on an empty channel: push only; the pop is impossible because x_valid=0.
- Push to one channel and pop from the other in the same cycle: the channels update independently.
- Ordering: FIFO order is preserved within each channel. There is no ordering guarantee across channels.
- x_ready asserted while x_valid=0 is ignored.
- in_valid may drop without acceptance. in_data/in_sel may change while in_valid=0.
- The producer must hold in_data/in_sel stable while in_valid && !in_ready.

Decomposition:
- Shared package: ALU_RESULT_W = 32, DEMUX_SEL_A = 1'b1, DEMUX_SEL_B = 1'b0. These select constants are shared with the ALU operand mux.
- Sub-module: demux_chan_fifo (WIDTH, DEPTH). It owns the memory, pointers, count, and valid/ready logic, and is instantiated twice.
- The top level holds only the select and in_ready logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and random data -> a_valid=b_valid=0 and counts=0. After release, the first push of 0x0000_1234 with sel=1 appears on a_data one edge later.
- Steering: push 0xAAAA_0001 (sel=1), then 0xBBBB_0002 (sel=0), with a_ready=b_ready=1 -> A delivers only 0xAAAA_0001 and B delivers only 0xBBBB_0002, each 1 cycle after acceptance.
- Full/backpressure: with a_ready=0, push 3 words with sel=1 at DEPTH=2 -> the first two are accepted, a_count=2, and in_ready=0 for the third. Switching sel to 0 with the same in_valid gives in_ready=1 (B not blocked).
- Full with pop: with A full, raise a_ready for one cycle while pushing to A -> in_ready stays 0 that cycle. The next cycle a_count=1 and in_ready=1.
- Wrap-around: stream 10 words 0..9 to B while toggling b_ready every cycle -> B outputs 0..9 in order, b_count never exceeds 2, and there are no duplicates or drops.
- Reset mid-operation: with A holding 2 entries, pulse rst_n low between edges -> a_valid falls immediately (asynchronously), and no stale word appears after release.
